// File: rtl/rtc_ad_responder.sv
// Device-side RTC model on a multiplexed 8-bit AD bus: address latch, snapshot reads,
// write commits and a BCD calendar advanced by a 1 Hz tick.
module rtc_ad_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        as,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        tick_1hz,
    inout  wire  [7:0]  data,
    output logic        bus_oe,
    output logic        wr_strobe,
    output logic [47:0] time_now
);
    localparam int unsigned DW = 8;

    localparam logic [DW-1:0] ADDR_CTRL  = 8'h10;
    localparam logic [DW-1:0] ADDR_SEC   = 8'h21;
    localparam logic [DW-1:0] ADDR_MIN   = 8'h22;
    localparam logic [DW-1:0] ADDR_HOUR  = 8'h23;
    localparam logic [DW-1:0] ADDR_DATE  = 8'h24;
    localparam logic [DW-1:0] ADDR_MONTH = 8'h25;
    localparam logic [DW-1:0] ADDR_YEAR  = 8'h26;

    // Strobe synchronisers: [0]/[1] are the two sync stages, [2] is the edge-detect copy.
    logic [1:0]    cs_sh;
    logic [2:0]    as_sh, rd_sh, wr_sh;
    logic [DW-1:0] data_s1, data_s2;

    logic [DW-1:0] addr_q, rd_q, rd_mux;
    logic [DW-1:0] ctrl_q, sec_q, min_q, hour_q, date_q, mon_q, year_q;
    logic          tick_pend;

    logic          as_fall, rd_fall, rd_stop, wr_rise, hold, tick_go;
    logic          leap;
    logic [DW-1:0] date_max;
    logic          sec_wrap, min_wrap, hour_wrap, date_wrap, mon_wrap, year_wrap;
    logic          c_min, c_hour, c_date, c_mon, c_year;
    logic [DW-1:0] sec_n, min_n, hour_n, date_n, mon_n, year_n;

    function automatic logic bcd_bad(input logic [DW-1:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
    endfunction

    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign data     = bus_oe ? rd_q : 8'bz;
    assign time_now = {year_q, mon_q, date_q, hour_q, min_q, sec_q};

    assign as_fall = as_sh[2] & ~as_sh[1] & ~cs_sh[1];
    assign rd_fall = rd_sh[2] & ~rd_sh[1] & ~cs_sh[1] & ~as_sh[1];
    assign rd_stop = rd_sh[1] | cs_sh[1];
    assign wr_rise = ~wr_sh[2] & wr_sh[1] & ~cs_sh[1];
    assign hold    = ctrl_q[0];
    assign tick_go = tick_1hz | tick_pend;

    // Leap year: BCD year divisible by 4 (tens even -> ones 0/4/8, tens odd -> ones 2/6).
    always_comb begin
        leap = year_q[4] ? ((year_q[3:0] == 4'd2) || (year_q[3:0] == 4'd6))
                         : ((year_q[3:0] == 4'd0) || (year_q[3:0] == 4'd4) || (year_q[3:0] == 4'd8));
        case (mon_q)
            8'h04, 8'h06, 8'h09, 8'h11: date_max = 8'h30;
            8'h02:                      date_max = leap ? 8'h29 : 8'h28;
            default:                    date_max = 8'h31;
        endcase
    end

    // Calendar increment: a field at/over its maximum or holding a bad digit wraps and carries.
    always_comb begin
        sec_wrap  = bcd_bad(sec_q)  || (sec_q  >= 8'h59);
        min_wrap  = bcd_bad(min_q)  || (min_q  >= 8'h59);
        hour_wrap = bcd_bad(hour_q) || (hour_q >= 8'h23);
        date_wrap = bcd_bad(date_q) || (date_q >= date_max);
        mon_wrap  = bcd_bad(mon_q)  || (mon_q  >= 8'h12);
        year_wrap = bcd_bad(year_q) || (year_q >= 8'h99);

        c_min  = sec_wrap;
        c_hour = c_min  & min_wrap;
        c_date = c_hour & hour_wrap;
        c_mon  = c_date & date_wrap;
        c_year = c_mon  & mon_wrap;

        sec_n  = sec_wrap ? 8'h00 : bcd_inc(sec_q);
        min_n  = !c_min  ? min_q  : (min_wrap  ? 8'h00 : bcd_inc(min_q));
        hour_n = !c_hour ? hour_q : (hour_wrap ? 8'h00 : bcd_inc(hour_q));
        date_n = !c_date ? date_q : (date_wrap ? 8'h01 : bcd_inc(date_q));
        mon_n  = !c_mon  ? mon_q  : (mon_wrap  ? 8'h01 : bcd_inc(mon_q));
        year_n = !c_year ? year_q : (year_wrap ? 8'h00 : bcd_inc(year_q));
    end

    always_comb begin
        case (addr_q)
            ADDR_CTRL:  rd_mux = ctrl_q;
            ADDR_SEC:   rd_mux = sec_q;
            ADDR_MIN:   rd_mux = min_q;
            ADDR_HOUR:  rd_mux = hour_q;
            ADDR_DATE:  rd_mux = date_q;
            ADDR_MONTH: rd_mux = mon_q;
            ADDR_YEAR:  rd_mux = year_q;
            default:    rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_sh     <= 2'b11;
            as_sh     <= 3'b000;
            rd_sh     <= 3'b111;
            wr_sh     <= 3'b111;
            data_s1   <= 8'h00;
            data_s2   <= 8'h00;
            addr_q    <= 8'h00;
            rd_q      <= 8'h00;
            bus_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            tick_pend <= 1'b0;
            ctrl_q    <= 8'h00;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_q    <= 8'h00;
            date_q    <= 8'h01;
            mon_q     <= 8'h01;
            year_q    <= 8'h00;
        end else begin
            cs_sh     <= {cs_sh[0], cs_n};
            as_sh     <= {as_sh[1:0], as};
            rd_sh     <= {rd_sh[1:0], rd_n};
            wr_sh     <= {wr_sh[1:0], wr_n};
            data_s1   <= data;
            data_s2   <= data_s1;
            wr_strobe <= 1'b0;

            if (as_fall) begin
                addr_q <= data_s2;
            end

            if (rd_fall) begin
                rd_q   <= rd_mux;
                bus_oe <= 1'b1;
            end else if (rd_stop) begin
                bus_oe <= 1'b0;
            end

            // A committing write owns the registers this cycle; a tick is deferred, not lost.
            if (wr_rise) begin
                wr_strobe <= 1'b1;
                tick_pend <= ~hold & tick_go;
                case (addr_q)
                    ADDR_CTRL:  ctrl_q <= data_s2;
                    ADDR_SEC:   sec_q  <= data_s2;
                    ADDR_MIN:   min_q  <= data_s2;
                    ADDR_HOUR:  hour_q <= data_s2;
                    ADDR_DATE:  date_q <= data_s2;
                    ADDR_MONTH: mon_q  <= data_s2;
                    ADDR_YEAR:  year_q <= data_s2;
                    default: ;
                endcase
            end else if (hold) begin
                tick_pend <= 1'b0;
            end else if (tick_go) begin
                tick_pend <= 1'b0;
                sec_q     <= sec_n;
                min_q     <= min_n;
                hour_q    <= hour_n;
                date_q    <= date_n;
                mon_q     <= mon_n;
                year_q    <= year_n;
            end
        end
    end
endmodule

// File: tb/tb_rtc_ad_responder.sv
// Self-checking bench for rtc_ad_responder: vector table, corner sequences and
// randomized bus traffic against a decimal calendar model.
module tb_rtc_ad_responder;
    logic        clk;
    logic        reset;
    logic        cs_n, as, rd_n, wr_n, tick_1hz;
    logic        host_oe;
    logic [7:0]  host_d;
    wire  [7:0]  data;
    logic        bus_oe, wr_strobe;
    logic [47:0] time_now;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] T_RESET = 48'h00_01_01_00_00_00;

    logic [7:0]  m_ctrl;
    logic [47:0] m_time;

    assign data = host_oe ? host_d : 8'bz;

    rtc_ad_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .as        (as),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .tick_1hz  (tick_1hz),
        .data      (data),
        .bus_oe    (bus_oe),
        .wr_strobe (wr_strobe),
        .time_now  (time_now)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Reference calendar: fields as decimal numbers, carry ripples from seconds upward.
    function automatic logic [47:0] advance(input logic [47:0] t);
        int f[6];
        bit bad[6];
        int lim[6];
        int lo[6];
        bit carry;
        logic [7:0] b;
        logic [47:0] r;
        r = t;
        for (int i = 0; i < 6; i++) begin
            b = t[8*i +: 8];
            bad[i] = (b[3:0] > 4'd9) || (b[7:4] > 4'd9);
            f[i] = int'(b[7:4]) * 10 + int'(b[3:0]);
        end
        lim = '{59, 59, 23, 31, 12, 99};
        lo  = '{0, 0, 0, 1, 1, 0};
        if (!bad[4] && (f[4] == 4 || f[4] == 6 || f[4] == 9 || f[4] == 11)) lim[3] = 30;
        else if (!bad[4] && f[4] == 2) lim[3] = (f[5] % 4 == 0) ? 29 : 28;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (bad[i] || f[i] >= lim[i]) f[i] = lo[i];
                else begin
                    f[i] = f[i] + 1;
                    carry = 1'b0;
                end
                r[8*i +: 8] = to_bcd(f[i]);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == 8'h10) return m_ctrl;
        if (a >= 8'h21 && a <= 8'h26) return m_time[8*int'(a - 8'h21) +: 8];
        return 8'h00;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] v);
        if (a == 8'h10) m_ctrl = v;
        else if (a >= 8'h21 && a <= 8'h26) m_time[8*int'(a - 8'h21) +: 8] = v;
    endtask

    task automatic addr_phase(input logic [7:0] a);
        cs_n = 1'b0;
        host_oe = 1'b1;
        host_d = a;
        step();
        as = 1'b1;
        repeat (4) step();
        as = 1'b0;
        repeat (5) step();
    endtask

    // Full write cycle; tmask[k] raises tick_1hz in the k-th cycle after wr_n rises.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] v, input logic [5:1] tmask,
                             output logic [5:1][47:0] tn);
        addr_phase(a);
        host_d = v;
        step();
        wr_n = 1'b0;
        repeat (4) step();
        wr_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick_1hz = tmask[k];
            step();
            tn[k] = time_now;
            chk($sformatf("wr_strobe a=%h k=%0d", a, k), 48'(wr_strobe), 48'(k == 3));
        end
        tick_1hz = 1'b0;
        host_oe = 1'b0;
        cs_n = 1'b1;
        step();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] val);
        addr_phase(a);
        host_oe = 1'b0;
        step();
        rd_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 3) chk($sformatf("oe_rise k=%0d", k), 48'(bus_oe), 48'(k == 3));
            if (k == 4) val = data;
        end
        rd_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 3) chk($sformatf("oe_fall k=%0d", k), 48'(bus_oe), 48'(k < 3));
        end
        cs_n = 1'b1;
        step();
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
        logic [5:1][47:0] tn;
        bus_write(a, v, 5'b00000, tn);
        model_write(a, v);
        chk($sformatf("time after write %h", a), time_now, m_time);
    endtask

    task automatic reg_read(input logic [7:0] a);
        logic [7:0] val;
        bus_read(a, val);
        chk($sformatf("read %h", a), 48'(val), 48'(model_read(a)));
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        if (!m_ctrl[0]) m_time = advance(m_time);
    endtask

    typedef struct {
        logic [47:0] start;
        logic [47:0] nxt;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    initial begin
        logic [5:1][47:0] tn;
        logic [47:0] saved;
        logic [7:0]  v, a, old_sec;
        logic [7:0]  al[8];
        int lo_f[6];
        int hi_f[6];
        int f, n;

        tbl[0]  = '{48'h99_12_31_23_59_59, 48'h00_01_01_00_00_00};
        tbl[1]  = '{48'h24_02_28_23_59_59, 48'h24_02_29_00_00_00};
        tbl[2]  = '{48'h23_02_28_23_59_59, 48'h23_03_01_00_00_00};
        tbl[3]  = '{48'h24_02_29_23_59_59, 48'h24_03_01_00_00_00};
        tbl[4]  = '{48'h25_04_30_23_59_59, 48'h25_05_01_00_00_00};
        tbl[5]  = '{48'h25_01_30_23_59_59, 48'h25_01_31_00_00_00};
        tbl[6]  = '{48'h25_06_15_12_34_59, 48'h25_06_15_12_35_00};
        tbl[7]  = '{48'h25_06_15_12_59_59, 48'h25_06_15_13_00_00};
        tbl[8]  = '{48'h25_06_15_12_00_09, 48'h25_06_15_12_00_10};
        tbl[9]  = '{48'h00_02_28_23_59_59, 48'h00_02_29_00_00_00};
        tbl[10] = '{48'h25_06_15_12_10_5A, 48'h25_06_15_12_11_00};
        tbl[11] = '{48'h25_06_15_12_10_1F, 48'h25_06_15_12_11_00};
        tbl[12] = '{48'h25_11_30_23_59_59, 48'h25_12_01_00_00_00};

        reset = 1'b0;
        cs_n = 1'b1; as = 1'b0; rd_n = 1'b1; wr_n = 1'b1; tick_1hz = 1'b0;
        host_oe = 1'b0; host_d = 8'h00;
        m_ctrl = 8'h00;
        m_time = T_RESET;
        step();
        step();
        reset = 1'b1;
        step();
        chk("reset bus_oe", 48'(bus_oe), 48'd0);
        chk("reset wr_strobe", 48'(wr_strobe), 48'd0);
        chk("reset time_now", time_now, T_RESET);
        reg_read(8'h10);

        // Write then read back seconds
        reg_write(8'h21, 8'h45);
        reg_read(8'h21);

        // Vector table of single-tick rollovers
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 6; k++) reg_write(8'(8'h21 + k), tbl[i].start[8*k +: 8]);
            chk($sformatf("load vec %0d", i), time_now, tbl[i].start);
            do_tick();
            chk($sformatf("tick vec %0d", i), time_now, tbl[i].nxt);
        end

        // Write/tick collision: write wins, tick applied one cycle later
        reg_write(8'h21, 8'h05);
        bus_write(8'h21, 8'h10, 5'b00100, tn);
        chk("collision sec at commit", 48'(tn[3][7:0]), 48'h10);
        chk("collision sec deferred", 48'(tn[4][7:0]), 48'h11);
        m_time[7:0] = 8'h11;
        // A second tick while one is pending is dropped
        bus_write(8'h21, 8'h10, 5'b01100, tn);
        chk("double tick sec k4", 48'(tn[4][7:0]), 48'h11);
        chk("double tick sec k5", 48'(tn[5][7:0]), 48'h11);
        m_time[7:0] = 8'h11;
        chk("time after collisions", time_now, m_time);

        // HOLD freezes time; a tick colliding with the write that clears HOLD is discarded
        reg_write(8'h10, 8'h01);
        saved = m_time;
        repeat (5) begin
            do_tick();
            chk("hold tick", time_now, saved);
        end
        bus_write(8'h10, 8'hA4, 5'b00100, tn);
        model_write(8'h10, 8'hA4);
        chk("hold discard k5", tn[5], saved);
        step();
        chk("hold discard later", time_now, saved);
        reg_read(8'h10);

        // Unmapped read and write
        reg_read(8'h30);
        reg_write(8'h30, 8'h77);
        reg_read(8'h30);

        // Snapshot stays put across a mid-read tick
        addr_phase(8'h21);
        host_oe = 1'b0;
        step();
        rd_n = 1'b0;
        repeat (3) step();
        old_sec = m_time[7:0];
        chk("snap before tick", 48'(data), 48'(old_sec));
        do_tick();
        step();
        chk("snap after tick", 48'(data), 48'(old_sec));
        chk("time during read", time_now, m_time);
        rd_n = 1'b1;
        repeat (4) step();
        cs_n = 1'b1;
        step();

        // cs_n deassertion mid-read releases the bus
        addr_phase(8'h22);
        host_oe = 1'b0;
        step();
        rd_n = 1'b0;
        repeat (3) step();
        chk("cs release pre", 48'(bus_oe), 48'd1);
        chk("cs release data", 48'(data), 48'(m_time[15:8]));
        cs_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("cs release k=%0d", k), 48'(bus_oe), 48'(k < 3));
        end
        rd_n = 1'b1;
        repeat (4) step();

        // Randomized traffic against the model
        lo_f = '{50, 50, 20, 1, 1, 0};
        hi_f = '{59, 59, 23, 28, 12, 99};
        al = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h3F};
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    f = $urandom_range(0, 5);
                    if ($urandom_range(0, 1) == 0) v = to_bcd($urandom_range(lo_f[f], hi_f[f]));
                    else v = to_bcd($urandom_range((f >= 3 && f <= 4) ? 1 : 0, hi_f[f]));
                    reg_write(8'(8'h21 + f), v);
                end
                1: begin
                    n = $urandom_range(1, 15);
                    repeat (n) begin
                        do_tick();
                        chk("rnd tick", time_now, m_time);
                        if ($urandom_range(0, 1) == 1) step();
                    end
                end
                2: reg_read(al[$urandom_range(0, 7)]);
                3: reg_write(8'h10, {7'($urandom), ($urandom_range(0, 3) == 0)});
                default: begin
                    a = 8'($urandom);
                    if (a == 8'h10 || (a >= 8'h21 && a <= 8'h26)) a = 8'h40;
                    reg_write(a, 8'($urandom));
                end
            endcase
        end

        // Reset mid-read releases the bus and overrides a simultaneous tick
        reg_write(8'h10, 8'h00);
        addr_phase(8'h23);
        host_oe = 1'b0;
        step();
        rd_n = 1'b0;
        repeat (3) step();
        chk("oe before reset", 48'(bus_oe), 48'd1);
        reset = 1'b0;
        tick_1hz = 1'b1;
        step();
        chk("oe after reset", 48'(bus_oe), 48'd0);
        chk("time after reset", time_now, T_RESET);
        tick_1hz = 1'b0;
        cs_n = 1'b1;
        rd_n = 1'b1;
        step();
        reset = 1'b1;
        step();
        m_ctrl = 8'h00;
        m_time = T_RESET;
        reg_read(8'h21);
        reg_read(8'h24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
